// File: rtl/ahb2apb_pkg.sv
// Shared types and helpers for the AHB-Lite to APB4 multi-slave bridge.
// Holds the FSM state encoding, AHB encodings and the byte-strobe helper.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RDONE  = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte lanes covered by a 2^size access at addr_lo on a 2^bus_log2-byte bus.
  // Result is 8 lanes wide; narrower buses use the low lanes only.
  function automatic logic [7:0] strb_from_size(input logic [2:0] size,
                                                input logic [2:0] addr_lo,
                                                input logic [2:0] bus_log2);
    logic [7:0] lane_mask;
    logic [2:0] base;
    lane_mask = 8'hFF;
    base      = 3'd0;
    if (size < bus_log2) begin
      case (size)
        3'd0:    begin lane_mask = 8'h01; base = addr_lo;                end
        3'd1:    begin lane_mask = 8'h03; base = {addr_lo[2:1], 1'b0};   end
        default: begin lane_mask = 8'h0F; base = {addr_lo[2], 2'b00};    end
      endcase
    end
    return lane_mask << base;
  endfunction

endpackage

// File: rtl/ahb2apb_strb_gen.sv
// PSTRB generator: write byte strobes from HSIZE and the low address bits.
// Reads always produce an all-zero strobe.
module ahb2apb_strb_gen
  import ahb2apb_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [2:0]             hsize,
  input  logic [2:0]             haddr_lo,
  input  logic                   hwrite,
  output logic [DATAWIDTH/8-1:0] pstrb
);

  localparam logic [2:0] BUS_LOG2 = (DATAWIDTH == 64) ? 3'd3 : 3'd2;

  logic [2:0] lane_addr;
  logic [7:0] strb_full;
  logic       unused_strb;

  // On a 32-bit bus address bit 2 selects a different word, not a lane.
  assign lane_addr   = (DATAWIDTH == 64) ? haddr_lo : {1'b0, haddr_lo[1:0]};
  assign strb_full   = strb_from_size(hsize, lane_addr, BUS_LOG2);
  assign pstrb       = hwrite ? strb_full[DATAWIDTH/8-1:0] : '0;
  assign unused_strb = ^strb_full;

endmodule

// File: rtl/ahb2apb_bridge_mux.sv
// AHB-Lite to APB4 bridge with HADDR-decoded slave selects, wait states,
// APB timeout and two-cycle AHB ERROR responses. APB side steps on PCLKEN.
module ahb2apb_bridge_mux
  import ahb2apb_pkg::*;
#(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int NUM_PSEL    = 4,
  parameter int RDATA_IFREG = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HSEL,
  input  logic [ADDRWIDTH-1:0]          HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic                          HWRITE,
  input  logic [2:0]                    HSIZE,
  input  logic [3:0]                    HPROT,
  input  logic [DATAWIDTH-1:0]          HWDATA,
  input  logic                          HREADY,
  output logic                          HREADYOUT,
  output logic                          HRESP,
  output logic [DATAWIDTH-1:0]          HRDATA,
  input  logic                          PCLKEN,
  output logic [NUM_PSEL-1:0]           PSEL,
  output logic                          PENABLE,
  output logic [ADDRWIDTH-1:0]          PADDR,
  output logic                          PWRITE,
  output logic [DATAWIDTH-1:0]          PWDATA,
  output logic [DATAWIDTH/8-1:0]        PSTRB,
  output logic [2:0]                    PPROT,
  input  logic [NUM_PSEL*DATAWIDTH-1:0] PRDATA,
  input  logic [NUM_PSEL-1:0]           PREADY,
  input  logic [NUM_PSEL-1:0]           PSLVERR,
  output logic                          APBACTIVE
);

  localparam int SEL_BITS = (NUM_PSEL > 1) ? $clog2(NUM_PSEL) : 1;
  localparam int TCNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SEL_BITS:0] NUM_PSEL_W = (SEL_BITS + 1)'(NUM_PSEL);
  localparam logic [TCNT_W-1:0] TLAST      = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                  state_reg, state_next;
  logic [ADDRWIDTH-1:0]    paddr_reg;
  logic                    pwrite_reg;
  logic [SEL_BITS-1:0]     idx_reg;
  logic [2:0]              pprot_reg;
  logic [DATAWIDTH/8-1:0]  pstrb_reg;
  logic [DATAWIDTH-1:0]    pwdata_reg;
  logic [DATAWIDTH-1:0]    hrdata_reg;
  logic [TCNT_W-1:0]       tcnt_reg;

  logic                    req;
  logic                    accept;
  logic [SEL_BITS-1:0]     hit_idx;
  logic                    decode_ok;
  logic [DATAWIDTH/8-1:0]  strb_new;
  logic [DATAWIDTH-1:0]    prdata_arr [NUM_PSEL];
  logic [DATAWIDTH-1:0]    prdata_sel;
  logic                    pready_sel;
  logic                    pslverr_sel;
  logic                    apb_sel;
  logic                    done;
  logic                    timeout_hit;
  logic                    rd_bypass;
  logic                    unused_ok;

  // req ignores HREADYOUT; the FSM only consults it in states driving HREADYOUT=1.
  assign req       = HSEL & HREADY & HTRANS[1];
  assign accept    = req & HREADYOUT;
  assign hit_idx   = HADDR[ADDRWIDTH-1 -: SEL_BITS];
  assign decode_ok = {1'b0, hit_idx} < NUM_PSEL_W;
  assign unused_ok = ^{HPROT[3:2], HTRANS[0]};

  ahb2apb_strb_gen #(.DATAWIDTH(DATAWIDTH)) u_strb (
    .hsize    (HSIZE),
    .haddr_lo (HADDR[2:0]),
    .hwrite   (HWRITE),
    .pstrb    (strb_new)
  );

  assign apb_sel = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PSEL; gi++) begin : g_slave
      assign prdata_arr[gi] = PRDATA[gi*DATAWIDTH +: DATAWIDTH];
      assign PSEL[gi]       = apb_sel && (idx_reg == SEL_BITS'(gi));
    end
  endgenerate

  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_PSEL; i++) begin
      if (idx_reg == SEL_BITS'(i)) begin
        prdata_sel  = prdata_arr[i];
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
      end
    end
  end

  assign done        = (state_reg == ST_ACCESS) && PCLKEN && pready_sel;
  assign timeout_hit = (TIMEOUT != 0) && (state_reg == ST_ACCESS) && PCLKEN &&
                       !pready_sel && (tcnt_reg == TLAST);

  always_comb begin
    state_next = state_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    rd_bypass  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) state_next = decode_ok ? ST_PEND : ST_ERR1;
      end
      ST_PEND: begin
        HREADYOUT = 1'b0;
        if (PCLKEN) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        HREADYOUT = 1'b0;
        if (PCLKEN) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        if (done) begin
          if (pslverr_sel) begin
            state_next = ST_ERR1;
          end else if (RDATA_IFREG != 0) begin
            state_next = ST_RDONE;
          end else begin
            HREADYOUT  = 1'b1;
            rd_bypass  = 1'b1;
            state_next = req ? (decode_ok ? ST_PEND : ST_ERR1) : ST_IDLE;
          end
        end else if (timeout_hit) begin
          state_next = ST_ERR1;
        end
      end
      ST_RDONE: begin
        state_next = req ? (decode_ok ? ST_PEND : ST_ERR1) : ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = HRESP_ERROR;
        state_next = req ? (decode_ok ? ST_PEND : ST_ERR1) : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg  <= ST_IDLE;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      idx_reg    <= '0;
      pprot_reg  <= '0;
      pstrb_reg  <= '0;
      pwdata_reg <= '0;
      hrdata_reg <= '0;
      tcnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        paddr_reg  <= {HADDR[ADDRWIDTH-1:2], 2'b00};
        pwrite_reg <= HWRITE;
        idx_reg    <= hit_idx;
        pprot_reg  <= {~HPROT[0], 1'b0, HPROT[1]};
        pstrb_reg  <= strb_new;
      end
      // HWDATA is the data phase of the accepted write, valid while pending.
      if (state_reg == ST_PEND && pwrite_reg) pwdata_reg <= HWDATA;
      if (state_reg == ST_SETUP) begin
        tcnt_reg <= '0;
      end else if (state_reg == ST_ACCESS && PCLKEN && !pready_sel) begin
        tcnt_reg <= tcnt_reg + TCNT_W'(1);
      end
      if (done && !pslverr_sel) hrdata_reg <= prdata_sel;
    end
  end

  assign HRDATA    = rd_bypass ? prdata_sel : hrdata_reg;
  assign PENABLE   = (state_reg == ST_ACCESS);
  assign PADDR     = paddr_reg;
  assign PWRITE    = pwrite_reg;
  assign PWDATA    = pwdata_reg;
  assign PSTRB     = pstrb_reg;
  assign PPROT     = pprot_reg;
  assign APBACTIVE = (HSEL & HTRANS[1]) | (state_reg != ST_IDLE);

endmodule

// File: doc/ahb2apb_bridge_mux.md
Name: ahb2apb_bridge_mux

Overview:
Synchronous AHB-Lite to APB4 bridge, successor to the single-slave bridge. Adds a parametrised number of APB slave selects decoded from HADDR, PSTRB generation from HSIZE/HADDR, PREADY wait states, and a two-cycle AHB ERROR response on PSLVERR, decode miss or APB timeout. The APB side advances only on HCLK edges where PCLKEN=1. It sits between the AHB interconnect slave port and an APB peripheral cluster.

Parameters:
ADDRWIDTH, 16, AHB/APB address width
DATAWIDTH, 32, data width; 32 or 64
NUM_PSEL, 4, number of APB slaves (1..16)
SEL_BITS, $clog2(NUM_PSEL) (min 1), upper HADDR bits used as slave index; derived
RDATA_IFREG, 1, 1 = register PRDATA and add one completion cycle
TIMEOUT, 0, max PCLKEN-qualified ACCESS cycles with PREADY low before abort; 0 disables

Ports:
HCLK  in  1  clock
HRESET  in  1  reset; synchronous, active-high
HSEL  in  1  bridge select
HADDR  in  ADDRWIDTH  address
HTRANS  in  2  transfer type
HWRITE  in  1  direction
HSIZE  in  3  transfer size
HPROT  in  4  protection
HWDATA  in  DATAWIDTH  write data
HREADY  in  1  bus ready
HREADYOUT  out  1  slave ready
HRESP  out  1  1 = ERROR
HRDATA  out  DATAWIDTH  read data
PCLKEN  in  1  APB clock enable
PSEL  out  NUM_PSEL  one-hot slave select
PENABLE  out  1  access phase
PADDR  out  ADDRWIDTH  word-aligned address
PWRITE  out  1  direction
PWDATA  out  DATAWIDTH  write data (registered)
PSTRB  out  DATAWIDTH/8  byte strobes
PPROT  out  3  protection
PRDATA  in  NUM_PSEL*DATAWIDTH  per-slave read data, slave i at [i*DATAWIDTH +: DATAWIDTH]
PREADY  in  NUM_PSEL  per-slave ready
PSLVERR  in  NUM_PSEL  per-slave error
APBACTIVE  out  1  clock-gating hint

Behaviour:
- Reset (HRESET=1 at HCLK edge): state IDLE, all registers 0. Outputs: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, HRDATA=0. Reset mid-transfer aborts immediately with no APB completion.
- accept = HSEL & HREADY & HTRANS[1] & HREADYOUT. Legal only in IDLE, RDONE, ERR2, and the ACCESS completion cycle.
- idx = HADDR[ADDRWIDTH-1 -: SEL_BITS]. decode_ok = idx < NUM_PSEL.
- On accept, capture: PADDR = {HADDR[ADDRWIDTH-1:2],2'b00}, HWRITE, idx, PPROT = {~HPROT[0],1'b0,HPROT[1]}, and PSTRB.
- PSTRB on writes: the 2^HSIZE bytes aligned at HADDR low bits; HSIZE >= log2(DATAWIDTH/8) gives all ones. PSTRB on reads: 0.
- States: IDLE, PEND, SETUP, ACCESS, RDONE, ERR1, ERR2.
- IDLE: accept & decode_ok -> PEND. accept & !decode_ok -> ERR1 (no APB cycle).
- PEND: HREADYOUT=0. HWDATA is registered into PWDATA every cycle when the transfer is a write. PCLKEN=1 -> SETUP.
- SETUP: PSEL[idx]=1, PENABLE=0, HREADYOUT=0. Timeout counter cleared. PCLKEN=1 -> ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. done = PCLKEN & PREADY[idx].
  - done & PSLVERR[idx] -> ERR1.
  - done & !PSLVERR & RDATA_IFREG=1 -> RDONE; HRDATA register loads PRDATA[idx].
  - done & !PSLVERR & RDATA_IFREG=0: HREADYOUT=1 this cycle, HRDATA = PRDATA[idx] combinationally. Next state is PEND if accept, else IDLE.
  - HREADYOUT=0 in ACCESS otherwise.
  - Counter increments on PCLKEN & !PREADY[idx]. TIMEOUT != 0 and counter reaches TIMEOUT -> ERR1, PSEL/PENABLE dropped.
- RDONE: HREADYOUT=1, HRESP=0. accept -> PEND (or ERR1 on decode miss), else IDLE.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1. accept -> PEND/ERR1, else IDLE.
- PSEL/PENABLE/PWRITE/PADDR stay stable from SETUP through ACCESS. All PSEL bits are 0 outside SETUP/ACCESS.
- Write latency, PCLKEN=1 and PREADY=1: address phase plus 3 wait cycles (PEND, SETUP, ACCESS-complete).
- APBACTIVE = (HSEL & HTRANS[1]) | (state != IDLE).
- HTRANS BUSY/IDLE never starts a transfer. HSEL low during a transfer does not abort it.

Decomposition:
- Package ahb2apb_pkg: state enum, HTRANS encodings, HRESP OKAY/ERROR constants, and a PSTRB-from-size function.
- Sub-module ahb2apb_strb_gen (HSIZE, HADDR low bits, HWRITE -> PSTRB).
- The FSM, decode, timeout counter and read mux stay in the top.

Test Plan:
- PCLKEN=1, write 0xDEADBEEF to 0x4008 (idx=1), HSIZE=2 -> PSEL=4'b0010, PADDR=0x4008, PSTRB=4'hF, PWDATA=0xDEADBEEF. HREADYOUT low exactly 3 cycles.
- Byte write to 0x0003 -> PSTRB=4'b1000. Halfword write to 0x0002 -> PSTRB=4'b1100. Any read -> PSTRB=0.
- Read from slave 2 with PREADY low for 2 PCLKEN cycles, PRDATA=0x12345678, RDATA_IFREG=1 -> HRDATA=0x12345678 in RDONE, HRESP=0.
- PSLVERR=1 at completion -> HREADYOUT=0/HRESP=1 for one cycle, then HREADYOUT=1/HRESP=1, then IDLE.
- TIMEOUT=4, PREADY stuck low -> abort after 4 PCLKEN cycles into the ERR1/ERR2 sequence. NUM_PSEL=3 with idx=3 -> ERROR with no PSEL asserted.
- PCLKEN every 3rd cycle with back-to-back reads, and HRESET asserted in ACCESS -> APB phases align to PCLKEN. Reset gives PSEL=0 and HREADYOUT=1 on the next edge.
